// File: rtl/fcmp_unit.sv
// fcmp_unit: two-stage FP compare execution stage (feq/flt/fle).
// S1 holds the issued op, S2 holds the registered result for writeback.
module fcmp_unit #(
    parameter int RD_W     = 5,
    parameter bit ILL_FLAG = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [31:0]     in_x1,
    input  logic [31:0]     in_x2,
    input  logic [RD_W-1:0] in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_nan,
    output logic            out_ill
);

    typedef struct packed {
        logic [1:0]      op;
        logic [31:0]     x1;
        logic [31:0]     x2;
        logic [RD_W-1:0] rd;
    } s1_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic both_zero(input logic [31:0] a, input logic [31:0] b);
        return (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    endfunction

    function automatic logic fequal(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b)) return 1'b0;
        if (both_zero(a, b)) return 1'b1;
        return a == b;
    endfunction

    // Sign-magnitude order: negatives compare with reversed magnitude.
    function automatic logic fless(input logic [31:0] a, input logic [31:0] b);
        if (is_nan(a) || is_nan(b)) return 1'b0;
        if (both_zero(a, b)) return 1'b0;
        if (a[31] != b[31]) return a[31];
        if (a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    logic            s1_valid_q;
    s1_t             s1_q;
    logic            s2_valid_q;
    logic            res_q;
    logic [RD_W-1:0] rd_q;
    logic            nan_q;
    logic            ill_q;

    logic            s2_adv;
    logic            accept;
    logic            eq;
    logic            less;
    logic            res_d;
    logic            nan_d;
    logic            ill_d;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign in_ready = (~s1_valid_q | s2_adv) & ~flush & rstn;
    assign accept   = in_valid & in_ready;

    always_comb begin
        eq    = fequal(s1_q.x1, s1_q.x2);
        less  = fless(s1_q.x1, s1_q.x2);
        nan_d = is_nan(s1_q.x1) | is_nan(s1_q.x2);
        res_d = 1'b0;
        ill_d = 1'b0;
        unique case (1'b1)
            (s1_q.op == 2'b00): res_d = eq;
            (s1_q.op == 2'b01): res_d = less;
            (s1_q.op == 2'b10): res_d = less | eq;
            (s1_q.op == 2'b11): begin
                res_d = ILL_FLAG ? 1'b0 : eq;
                ill_d = ILL_FLAG;
            end
            default: res_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            res_q      <= 1'b0;
            rd_q       <= '0;
            nan_q      <= 1'b0;
            ill_q      <= 1'b0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q <= res_d;
                    rd_q  <= s1_q.rd;
                    nan_q <= nan_d;
                    ill_q <= ill_d;
                end
            end
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_q       <= '{op: in_op, x1: in_x1, x2: in_x2, rd: in_rd};
            end else if (s2_adv) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = {31'd0, res_q};
    assign out_rd    = rd_q;
    assign out_nan   = nan_q;
    assign out_ill   = ill_q;

endmodule

// File: tb/tb_fcmp_unit.sv
// tb_fcmp_unit: directed self-checking bench for fcmp_unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fcmp_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_x1;
    logic [31:0] in_x2;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_nan;
    logic        out_ill;

    int checks   = 0;
    int failures = 0;

    fcmp_unit #(.RD_W(5), .ILL_FLAG(1'b1)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_x1     (in_x1),
        .in_x2     (in_x2),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_rd    (out_rd),
        .out_nan   (out_nan),
        .out_ill   (out_ill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
        in_valid = 1'b1;
        in_op    = op;
        in_x1    = a;
        in_x2    = b;
        in_rd    = rd;
    endtask

    task automatic run_one(input string tag, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic ed,
                           input logic en, input logic ei);
        out_ready = 1'b1;
        present(op, a, b, rd);
        #1 chk({tag, ".in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".early"}, out_valid, 0);
        @(negedge clk);
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".data"}, out_data, {31'd0, ed});
        chk({tag, ".rd"}, out_rd, rd);
        chk({tag, ".nan"}, out_nan, en);
        chk({tag, ".ill"}, out_ill, ei);
    endtask

    initial begin
        int  sent;
        int  got;
        int  cyc;
        bit  blocked;

        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_x1     = '0;
        in_x2     = '0;
        in_rd     = '0;
        out_ready = 1'b1;

        @(negedge clk);
        chk("rst.in_ready", in_ready, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_data", out_data, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle.out_valid", out_valid, 0);

        run_one("feq_1_1", 2'b00, 32'h3F800000, 32'h3F800000, 5'd1, 1, 0, 0);
        run_one("flt_m0_p0", 2'b01, 32'h80000000, 32'h00000000, 5'd2, 0, 0, 0);
        run_one("fle_m0_p0", 2'b10, 32'h80000000, 32'h00000000, 5'd3, 1, 0, 0);
        run_one("feq_m0_p0", 2'b00, 32'h80000000, 32'h00000000, 5'd4, 1, 0, 0);
        run_one("flt_m1_m2", 2'b01, 32'hBF800000, 32'hC0000000, 5'd5, 0, 0, 0);
        run_one("flt_m2_m1", 2'b01, 32'hC0000000, 32'hBF800000, 5'd6, 1, 0, 0);
        run_one("flt_1_2", 2'b01, 32'h3F800000, 32'h40000000, 5'd7, 1, 0, 0);
        run_one("fle_2_1", 2'b10, 32'h40000000, 32'h3F800000, 5'd8, 0, 0, 0);
        run_one("flt_m1_p1", 2'b01, 32'hBF800000, 32'h3F800000, 5'd9, 1, 0, 0);
        run_one("fle_qnan", 2'b10, 32'h7FC00000, 32'h3F800000, 5'd10, 0, 1, 0);
        run_one("feq_nan2", 2'b00, 32'h3F800000, 32'hFF800001, 5'd11, 0, 1, 0);
        run_one("op11", 2'b11, 32'h3F800000, 32'h3F800000, 5'd12, 0, 0, 1);
        run_one("feq_inf", 2'b00, 32'h7F800000, 32'h7F800000, 5'd13, 1, 0, 0);

        // Eight back-to-back flt ops, writeback stalls for cycles 3..5.
        @(negedge clk);
        sent    = 0;
        got     = 0;
        cyc     = 0;
        blocked = 1'b0;
        while (got < 8 && cyc < 40) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid  = (sent < 8);
            in_op     = 2'b01;
            in_x1     = 32'h40000000 + 32'(sent);
            in_x2     = 32'h40000004;
            in_rd     = 5'(16 + sent);
            #1;
            if (in_valid && !in_ready) blocked = 1'b1;
            if (out_valid && out_ready) begin
                chk($sformatf("b2b.data%0d", got), out_data, (got < 4) ? 1 : 0);
                chk($sformatf("b2b.rd%0d", got), out_rd, 32'(16 + got));
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("b2b.count", got, 8);
        chk("b2b.blocked", blocked, 1);
        chk("b2b.cycles", cyc, 13);
        chk("b2b.nodup", out_valid, 0);

        // Fill both stages, then flush with a new op presented.
        out_ready = 1'b0;
        present(2'b00, 32'h3F800000, 32'h3F800000, 5'd20);
        @(negedge clk);
        present(2'b00, 32'h3F800000, 32'h3F800000, 5'd21);
        @(negedge clk);
        chk("fl.full_valid", out_valid, 1);
        chk("fl.full_ready", in_ready, 0);
        out_ready = 1'b1;
        flush     = 1'b1;
        present(2'b01, 32'h3F800000, 32'h40000000, 5'd22);
        #1 chk("fl.in_ready", in_ready, 0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl.out_valid", out_valid, 0);
        @(negedge clk);
        chk("fl.no_ghost", out_valid, 0);
        run_one("fl.after", 2'b10, 32'h3F800000, 32'h40000000, 5'd23, 1, 0, 0);

        // Async reset between edges while results are in flight.
        @(negedge clk);
        out_ready = 1'b0;
        present(2'b00, 32'h3F800000, 32'h3F800000, 5'd24);
        @(negedge clk);
        present(2'b00, 32'h3F800000, 32'h3F800000, 5'd25);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rs.pre_valid", out_valid, 1);
        chk("rs.pre_data", out_data, 1);
        #2 rstn = 1'b0;
        #1;
        chk("rs.out_valid", out_valid, 0);
        chk("rs.out_data", out_data, 0);
        chk("rs.out_rd", out_rd, 0);
        chk("rs.in_ready", in_ready, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1 chk("rs.released", out_valid, 0);
        @(negedge clk);
        run_one("rs.after", 2'b01, 32'hBF800000, 32'h00000000, 5'd26, 1, 0, 0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
